// File: rtl/radio_pkg.sv
// Shared types and constants for the RC receiver PWM decoder.
package radio_pkg;

    typedef enum logic [1:0] {
        WAIT_LOW,
        WAIT_RISE,
        MEASURE
    } cap_state_t;

    localparam int VAL_W = 10;
    localparam int WID_W = 12;
    localparam int TO_W  = 16;

    localparam logic [VAL_W-1:0] FS_THRL = 10'd0;
    localparam logic [VAL_W-1:0] FS_MID  = 10'd512;

endpackage

// File: rtl/pwm_capture.sv
// One PWM channel: synchronizer, pulse-width FSM, plausibility check,
// microsecond-to-stick-value mapping and no-signal failsafe.
module pwm_capture
    import radio_pkg::*;
#(
    parameter int               MIN_US     = 988,
    parameter int               REJ_LO_US  = 800,
    parameter int               REJ_HI_US  = 2200,
    parameter int               TIMEOUT_US = 50000,
    parameter logic [VAL_W-1:0] FAILSAFE   = FS_MID
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm,
    input  logic             us_tick,
    output logic [VAL_W-1:0] val,
    output logic             valid,
    output logic             upd
);

    localparam logic [WID_W-1:0]  REJ_LO  = WID_W'(REJ_LO_US);
    localparam logic [WID_W-1:0]  REJ_HI  = WID_W'(REJ_HI_US);
    localparam logic [TO_W-1:0]   TIMEOUT = TO_W'(TIMEOUT_US);
    localparam logic signed [12:0] MIN_S  = 13'(MIN_US);

    logic              sync1, sync2, prev;
    logic              rise, fall;
    cap_state_t        state, state_nxt;
    logic [WID_W-1:0]  width, width_inc;
    logic [TO_W-1:0]   to_cnt;
    logic              clr_width, count_en, evaluate, accept, timed_out;
    logic signed [12:0] diff;
    logic [VAL_W-1:0]  val_new;

    // NOTE: synchronizer resets high so a pin already high at reset exit is not seen as a rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= pwm;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;
    assign fall = ~sync2 & prev;

    always_ff @(posedge clk) begin
        if (rst) state <= WAIT_LOW;
        else     state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            WAIT_LOW:  if (!sync2) state_nxt = WAIT_RISE;
            WAIT_RISE: if (rise)   state_nxt = MEASURE;
            MEASURE:   if (fall)   state_nxt = WAIT_RISE;
            default:               state_nxt = WAIT_LOW;
        endcase
    end

    always_comb begin
        clr_width = 1'b0;
        count_en  = 1'b0;
        evaluate  = 1'b0;
        unique case (state)
            WAIT_RISE: clr_width = rise;
            MEASURE: begin
                count_en = 1'b1;
                evaluate = fall;
            end
            default: ;
        endcase
    end

    // The falling-edge cycle's tick is included so the width is exact for whole-microsecond pulses.
    assign width_inc = (us_tick && (width != '1)) ? width + 1'b1 : width;
    assign accept    = evaluate && (width_inc >= REJ_LO) && (width_inc <= REJ_HI);
    assign timed_out = (to_cnt == TIMEOUT);
    assign diff      = $signed({1'b0, width_inc}) - MIN_S;

    always_comb begin
        val_new = diff[VAL_W-1:0];
        if (diff < 13'sd0)         val_new = '0;
        else if (diff > 13'sd1023) val_new = '1;
    end

    always_ff @(posedge clk) begin
        if (rst)            width <= '0;
        else if (clr_width) width <= '0;
        else if (count_en)  width <= width_inc;
    end

    always_ff @(posedge clk) begin
        if (rst)                        to_cnt <= '0;
        else if (accept)                to_cnt <= '0;
        else if (us_tick && !timed_out) to_cnt <= to_cnt + 1'b1;
    end

    // An accepted pulse takes priority over a timeout landing in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            val   <= FAILSAFE;
            valid <= 1'b0;
            upd   <= 1'b0;
        end else begin
            upd <= accept;
            if (accept) begin
                val   <= val_new;
                valid <= 1'b1;
            end else if (timed_out) begin
                val   <= FAILSAFE;
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/radio_decoder.sv
// Multi-channel RC PWM decoder: shared microsecond prescaler feeding one
// pwm_capture per channel.
module radio_decoder
    import radio_pkg::*;
#(
    parameter int NUM_CH     = 6,
    parameter int CLK_PER_US = 50,
    parameter int MIN_US     = 988,
    parameter int REJ_LO_US  = 800,
    parameter int REJ_HI_US  = 2200,
    parameter int TIMEOUT_US = 50000,
    parameter int THRL_CH    = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       pwm_i,
    output logic [NUM_CH*VAL_W-1:0] vals_o,
    output logic [NUM_CH-1:0]       valid_o,
    output logic [NUM_CH-1:0]       upd_o
);

    localparam int PS_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

    logic [PS_W-1:0] ps_cnt;
    logic            us_tick;

    assign us_tick = (ps_cnt == PS_W'(CLK_PER_US - 1));

    always_ff @(posedge clk) begin
        if (rst)          ps_cnt <= '0;
        else if (us_tick) ps_cnt <= '0;
        else              ps_cnt <= ps_cnt + 1'b1;
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        pwm_capture #(
            .MIN_US    (MIN_US),
            .REJ_LO_US (REJ_LO_US),
            .REJ_HI_US (REJ_HI_US),
            .TIMEOUT_US(TIMEOUT_US),
            .FAILSAFE  ((n == THRL_CH) ? FS_THRL : FS_MID)
        ) u_cap (
            .clk    (clk),
            .rst    (rst),
            .pwm    (pwm_i[n]),
            .us_tick(us_tick),
            .val    (vals_o[VAL_W*n +: VAL_W]),
            .valid  (valid_o[n]),
            .upd    (upd_o[n])
        );
    end

endmodule

// File: tb/tb_radio_decoder.sv
// Scoreboard bench for radio_decoder, run with a short prescaler and timeout
// so the whole sequence stays compact.
module tb_radio_decoder;

    localparam int NUM_CH     = 6;
    localparam int CPU        = 2;
    localparam int MIN_US     = 988;
    localparam int REJ_LO_US  = 800;
    localparam int REJ_HI_US  = 2200;
    localparam int TIMEOUT_US = 4000;

    typedef struct {
        int         ch;
        logic [9:0] val;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_CH-1:0]    pwm_i = '0;
    logic [NUM_CH*10-1:0] vals_o;
    logic [NUM_CH-1:0]    valid_o;
    logic [NUM_CH-1:0]    upd_o;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    logic [NUM_CH*10-1:0] rst_vals;

    radio_decoder #(
        .NUM_CH    (NUM_CH),
        .CLK_PER_US(CPU),
        .MIN_US    (MIN_US),
        .REJ_LO_US (REJ_LO_US),
        .REJ_HI_US (REJ_HI_US),
        .TIMEOUT_US(TIMEOUT_US),
        .THRL_CH   (0)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .pwm_i  (pwm_i),
        .vals_o (vals_o),
        .valid_o(valid_o),
        .upd_o  (upd_o)
    );

    always #5 clk = ~clk;

    initial begin
        #(200_000 * 10);
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    function automatic logic [9:0] model_val(input int w);
        int d;
        d = w - MIN_US;
        if (d < 0)    return 10'd0;
        if (d > 1023) return 10'd1023;
        return d[9:0];
    endfunction

    // Monitor: every upd strobe must match the oldest outstanding expectation.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (upd_o[ch]) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_upd ch=%0d value=%0d required=no strobe", ch, vals_o[ch*10 +: 10]);
                    end else begin
                        mon_e = sb_q.pop_front();
                        if (mon_e.ch != ch || vals_o[ch*10 +: 10] !== mon_e.val || valid_o[ch] !== 1'b1) begin
                            failures++;
                            $display("FAIL sb_value ch=%0d value=%0d valid=%b required ch=%0d value=%0d valid=1",
                                     ch, vals_o[ch*10 +: 10], valid_o[ch], mon_e.ch, mon_e.val);
                        end
                    end
                end
            end
        end
    end

    task automatic wait_us(input int us);
        repeat (us * CPU) @(posedge clk);
        #1;
    endtask

    // Drives one pulse on every channel in mask; checks the strobe lands exactly 3 clk after the fall.
    task automatic pulse(input logic [NUM_CH-1:0] mask, input int width_us, input int gap_us);
        logic acc;
        logic [NUM_CH-1:0] exp_upd;
        acc     = (width_us >= REJ_LO_US) && (width_us <= REJ_HI_US);
        exp_upd = acc ? mask : '0;
        @(posedge clk);
        #1 pwm_i = pwm_i | mask;
        repeat (width_us * CPU) @(posedge clk);
        #1 pwm_i = pwm_i & ~mask;
        if (acc)
            for (int ch = 0; ch < NUM_CH; ch++)
                if (mask[ch]) sb_q.push_back('{ch, model_val(width_us)});
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ((upd_o & mask) !== '0) begin
            failures++;
            $display("FAIL upd_early width=%0d upd=%b required=%b", width_us, upd_o & mask, 6'b0);
        end
        @(posedge clk);
        #1;
        checks++;
        if ((upd_o & mask) !== exp_upd) begin
            failures++;
            $display("FAIL upd_latency width=%0d upd=%b required=%b", width_us, upd_o & mask, exp_upd);
        end
        repeat (gap_us * CPU) @(posedge clk);
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        pwm_i = '0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (vals_o !== rst_vals || valid_o !== '0 || upd_o !== '0) begin
            failures++;
            $display("FAIL reset_state vals=%h valid=%b upd=%b required vals=%h valid=0 upd=0",
                     vals_o, valid_o, upd_o, rst_vals);
        end
        rst = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_nominal();
        pulse(6'b000010, 1500, 50);
        pulse(6'b000010, 1500, 50);
        #1;
        checks++;
        if (vals_o[19:10] !== 10'd512 || valid_o[1] !== 1'b1) begin
            failures++;
            $display("FAIL nominal_ch1 value=%0d valid=%b required value=512 valid=1", vals_o[19:10], valid_o[1]);
        end
    endtask

    task automatic test_reject();
        pulse(6'b000100, 1200, 50);
        pulse(6'b000100, 750, 50);
        checks++;
        if (vals_o[29:20] !== 10'd212) begin
            failures++;
            $display("FAIL reject_short value=%0d required=212", vals_o[29:20]);
        end
        pulse(6'b000100, 2300, 50);
        checks++;
        if (vals_o[29:20] !== 10'd212 || valid_o[2] !== 1'b1) begin
            failures++;
            $display("FAIL reject_long value=%0d valid=%b required value=212 valid=1", vals_o[29:20], valid_o[2]);
        end
        // Rejected pulses must not have restarted the timeout, so it expires about 4000 us after the 1200 us pulse.
        wait_us(1000);
        checks++;
        if (valid_o[2] !== 1'b0 || vals_o[29:20] !== 10'd512) begin
            failures++;
            $display("FAIL reject_timeout value=%0d valid=%b required value=512 valid=0", vals_o[29:20], valid_o[2]);
        end
        pulse(6'b000100, 800, 50);
        pulse(6'b000100, 2200, 50);
    endtask

    task automatic test_clamp_timeout();
        pulse(6'b001000, 1300, 50);
        pulse(6'b000001, 900, 50);
        checks++;
        if (vals_o[9:0] !== 10'd0) begin
            failures++;
            $display("FAIL clamp_low value=%0d required=0", vals_o[9:0]);
        end
        pulse(6'b000001, 2100, 0);
        wait_us(TIMEOUT_US - 10);
        checks++;
        if (valid_o[0] !== 1'b1 || vals_o[9:0] !== 10'd1023) begin
            failures++;
            $display("FAIL pre_timeout value=%0d valid=%b required value=1023 valid=1", vals_o[9:0], valid_o[0]);
        end
        wait_us(20);
        checks++;
        if (valid_o[0] !== 1'b0 || vals_o[9:0] !== 10'd0) begin
            failures++;
            $display("FAIL timeout_ch0 value=%0d valid=%b required value=0 valid=0", vals_o[9:0], valid_o[0]);
        end
        checks++;
        if (valid_o[3] !== 1'b0 || vals_o[39:30] !== 10'd512) begin
            failures++;
            $display("FAIL timeout_ch3 value=%0d valid=%b required value=512 valid=0", vals_o[39:30], valid_o[3]);
        end
        pulse(6'b000001, 1500, 50);
        checks++;
        if (valid_o[0] !== 1'b1 || vals_o[9:0] !== 10'd512) begin
            failures++;
            $display("FAIL recover_ch0 value=%0d valid=%b required value=512 valid=1", vals_o[9:0], valid_o[0]);
        end
    endtask

    task automatic test_reset_exit();
        @(posedge clk);
        #1 rst = 1'b1;
        pwm_i[4] = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        wait_us(600);
        pwm_i[4] = 1'b0;
        wait_us(20);
        checks++;
        if (valid_o[4] !== 1'b0 || vals_o[49:40] !== 10'd512) begin
            failures++;
            $display("FAIL reset_exit_partial value=%0d valid=%b required value=512 valid=0", vals_o[49:40], valid_o[4]);
        end
        pulse(6'b010000, 1012, 50);
        checks++;
        if (vals_o[49:40] !== 10'd24) begin
            failures++;
            $display("FAIL reset_exit_next value=%0d required=24", vals_o[49:40]);
        end
    endtask

    task automatic test_reset_midpulse();
        pulse(6'b100000, 1100, 50);
        @(posedge clk);
        #1 pwm_i[5] = 1'b1;
        wait_us(400);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (vals_o !== rst_vals || valid_o !== '0 || upd_o !== '0) begin
            failures++;
            $display("FAIL midpulse_reset vals=%h valid=%b upd=%b required vals=%h valid=0 upd=0",
                     vals_o, valid_o, upd_o, rst_vals);
        end
        rst = 1'b0;
        wait_us(600);
        pwm_i[5] = 1'b0;
        wait_us(20);
        checks++;
        if (valid_o[5] !== 1'b0 || vals_o[59:50] !== 10'd512) begin
            failures++;
            $display("FAIL midpulse_partial value=%0d valid=%b required value=512 valid=0", vals_o[59:50], valid_o[5]);
        end
        pulse(6'b100000, 1100, 50);
    endtask

    task automatic test_back_to_back();
        pulse(6'b001010, 1600, 50);
        checks++;
        if (vals_o[19:10] !== 10'd612 || vals_o[39:30] !== 10'd612) begin
            failures++;
            $display("FAIL same_cycle ch1=%0d ch3=%0d required ch1=612 ch3=612", vals_o[19:10], vals_o[39:30]);
        end
    endtask

    initial begin
        rst_vals = {10'd512, 10'd512, 10'd512, 10'd512, 10'd512, 10'd0};
        test_reset();
        test_nominal();
        test_reject();
        test_clamp_timeout();
        test_reset_exit();
        test_reset_midpulse();
        test_back_to_back();
        wait_us(5);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain outstanding=%0d required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/radio_decoder.md
# radio_decoder

Multi-channel RC receiver PWM decoder that sits directly upstream of the arming/data flag logic. It measures each channel's high-pulse width in microseconds and rejects implausible pulses. Accepted widths become 10-bit stick values (0..1023), such as the throttle and elevator values consumed downstream. It applies a failsafe value and drops a per-channel valid bit when a channel stops producing pulses.

## Interface
- `NUM_CH`, 6: number of PWM channels.
- `CLK_PER_US`, 50: clk cycles per microsecond (50 MHz clk).
- `MIN_US`, 988: pulse width mapped to value 0; `MIN_US+1023` maps to 1023.
- `REJ_LO_US`, 800: widths below this are rejected.
- `REJ_HI_US`, 2200: widths above this are rejected.
- `TIMEOUT_US`, 50000: no accepted pulse for this long enters failsafe.
- `THRL_CH`, 0: channel whose failsafe value is 0. All other channels fail safe to 512.

Ports:
- `clk`, input, 1: single clock.
- `rst`, input, 1: synchronous, active-high reset.
- `pwm_i`, input, `NUM_CH`: raw asynchronous receiver pins.
- `vals_o`, output, `NUM_CH*10`: packed values; channel n is at `[10n+9:10n]`.
- `valid_o`, output, `NUM_CH`: channel n has an accepted pulse within `TIMEOUT_US`.
- `upd_o`, output, `NUM_CH`: one-cycle strobe when channel n's value is written by an accepted pulse.

## Operation
- Each `pwm_i` bit passes through a 2-flop synchronizer, followed by a registered previous-sample flop for edge detection.
- The top level has one free-running prescaler, 0..`CLK_PER_US`-1. It pulses `us_tick` for one cycle on wrap.
  - The prescaler is not gated by pin activity.
  - It is cleared by `rst`.
- Per-channel FSM:
  - **WAIT_LOW**: the reset state. Go to WAIT_RISE once the synchronized pin is 0. This discards a pulse already in progress at reset exit.
  - **WAIT_RISE**: on a rising edge, clear the 12-bit width counter and go to MEASURE.
  - **MEASURE**: the width counter increments on each `us_tick` and saturates at 4095. On a falling edge, evaluate the width and go to WAIT_RISE.
- Evaluation on a falling edge, with w = width counter:
  - If `REJ_LO_US` ≤ w ≤ `REJ_HI_US`, the pulse is accepted:
    - value = w−`MIN_US`, clamped to 0..1023;
    - write the value, assert `upd_o` for one cycle, set `valid_o`, clear the timeout counter.
  - Otherwise the pulse is rejected: the value is held, no `upd_o`, and the timeout counter keeps running.
- Timeout:
  - A 16-bit timeout counter increments on `us_tick` in every state and saturates.
  - When it reaches `TIMEOUT_US`:
    - `valid_o` goes to 0;
    - the value is forced to failsafe (0 if n==`THRL_CH`, else 512);
    - the counter holds.
  - The next accepted pulse restores normal operation.
- Arithmetic: perform the subtraction at 13 bits signed. Negative results clamp to 0 and results above 1023 clamp to 1023.
- Simultaneous events: if an accepted pulse evaluates in the same cycle the timeout counter reaches `TIMEOUT_US`, the accepted pulse wins.

## Timing
- Reset values:
  - `vals_o`: all channels at failsafe (channel `THRL_CH`=0, others=512);
  - `valid_o`=0, `upd_o`=0;
  - all FSMs in WAIT_LOW, all counters 0.
- Latency: `vals_o`/`upd_o` update on the 3rd rising clk edge after the first edge that samples `pwm_i` low (2 synchronizer edges + 1 output register edge).
  - `valid_o` and the value change in the same cycle as `upd_o`.
- Width quantization is ±1 µs, from the prescaler phase.
- `rst` asserted mid-pulse aborts the measurement. The pulse in progress is never reported.
- Channels are fully independent. Any mix of same-cycle edges across channels is legal.

## Structure
- Shared package `radio_pkg` holds:
  - the FSM state enum (WAIT_LOW, WAIT_RISE, MEASURE);
  - value width 10, width-counter width 12, timeout-counter width 16;
  - failsafe constants 0 and 512.
- Sub-module `pwm_capture`: one channel, containing the synchronizer, FSM, width/timeout counters and output register.
  - It takes `us_tick` as an input.
  - The top level generates the prescaler and instantiates `NUM_CH` copies.

## Test plan
- After reset, drive 1500 µs pulses every 20 ms on channel 1 -> `vals_o[19:10]`=512, `valid_o[1]`=1, with one `upd_o[1]` strobe per pulse, 3 clk after the pin falls.
- Channel 0 pulses of 900 µs, then 2100 µs -> value 0 (clamp low), then 1023 (clamp high), both accepted with `upd_o`.
- Channel 2 at 1200 µs, then a 750 µs pulse and a 2300 µs pulse -> value stays 212, no `upd_o`, timeout not cleared.
- Pulses stop on channels 0 and 3 -> 50000 µs after the last accepted pulse, ch0=0 and ch3=512 with `valid_o` low. The next 1500 µs pulse restores ch0=512 and `valid_o`=1.
- Release `rst` with `pwm_i[4]` high for 600 µs of a pulse -> no update for that pulse. The next full 1012 µs pulse yields 24.
- Assert `rst` 400 µs into a channel 5 pulse -> outputs return to reset values and the partial pulse is never reported.
